// File: rtl/line_buf_ctrl.sv
// Ping-pong scanline buffer sequencer between the PPU pixel stream and VGA scanout.
// Optional macro LBC_RESYNC_EN: ppu_line_start realigns the PPU line counter.
module line_buf_ctrl #(
   parameter int unsigned PPU_LINE_LEN  = 1600,
   parameter int unsigned STARTUP_DELAY = 3199,
   parameter int unsigned ADDR_W        = 10
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              ppu_line_start,
   input  logic              vga_line_start,
   input  logic              err_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              vga_en,
   output logic              underrun,
   output logic              overrun
);

   localparam int unsigned X_W  = ADDR_W + 1;
   localparam int unsigned ST_W = $clog2(STARTUP_DELAY + 1);
   localparam logic [X_W-1:0]  X_LAST  = X_W'(PPU_LINE_LEN - 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARTUP_DELAY);

   typedef enum logic {ST_STARTUP, ST_RUN} state_e;

   state_e          state_q, state_d;
   logic [X_W-1:0]  x_cnt_q, x_cnt_d;
   logic [ST_W-1:0] st_cnt_q, st_cnt_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic            ready_bank_q, ready_bank_d;
   logic            line_ready_q, line_ready_d;
   logic            underrun_q, underrun_d;
   logic            overrun_q, overrun_d;

   logic            resync_hit;
   logic            line_done;
   logic            handoff;
   logic            set_under;
   logic            set_over;

`ifndef LBC_RESYNC_EN
   logic            resync_unused;
   assign resync_unused = ppu_line_start;
`endif

   always_comb begin
      x_cnt_d    = (x_cnt_q == X_LAST) ? '0 : x_cnt_q + 1'b1;
      resync_hit = 1'b0;
`ifdef LBC_RESYNC_EN
      if (ppu_line_start && (x_cnt_q != '0)) begin
         resync_hit = 1'b1;
         x_cnt_d    = '0;
      end
`endif
      line_done = (x_cnt_q == X_LAST) && !resync_hit;
   end

   always_comb begin
      state_d  = state_q;
      st_cnt_d = st_cnt_q;
      case (state_q)
         ST_STARTUP: begin
            if (st_cnt_q == ST_LAST) state_d = ST_RUN;
            else                     st_cnt_d = st_cnt_q + 1'b1;
         end
         ST_RUN: state_d = ST_RUN;
      endcase
   end

   assign handoff = (state_q == ST_RUN) && vga_line_start;

   // A completion coinciding with a VGA line start hands the fresh bank straight over.
   always_comb begin
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      ready_bank_d = ready_bank_q;
      line_ready_d = line_ready_q;
      set_under    = 1'b0;
      set_over     = 1'b0;
      if (line_done) begin
         wr_bank_d    = ~wr_bank_q;
         ready_bank_d = wr_bank_q;
      end
      if (line_done && handoff) begin
         rd_bank_d    = wr_bank_q;
         line_ready_d = 1'b0;
      end else if (line_done) begin
         line_ready_d = 1'b1;
         set_over     = line_ready_q;
      end else if (handoff) begin
         if (line_ready_q) begin
            rd_bank_d    = ready_bank_q;
            line_ready_d = 1'b0;
         end else begin
            set_under = 1'b1;
         end
      end
      underrun_d = set_under | (underrun_q & ~err_clr);
      overrun_d  = set_over  | (overrun_q  & ~err_clr);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= ST_STARTUP;
         x_cnt_q      <= '0;
         st_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         ready_bank_q <= 1'b0;
         line_ready_q <= 1'b0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_cnt_q      <= x_cnt_d;
         st_cnt_q     <= st_cnt_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         ready_bank_q <= ready_bank_d;
         line_ready_q <= line_ready_d;
         underrun_q   <= underrun_d;
         overrun_q    <= overrun_d;
      end
   end

   assign wr_en    = ~x_cnt_q[0] & ~rst;
   assign wr_addr  = x_cnt_q[ADDR_W:1];
   assign wr_bank  = wr_bank_q;
   assign rd_bank  = rd_bank_q;
   assign vga_en   = (state_q == ST_RUN);
   assign underrun = underrun_q;
   assign overrun  = overrun_q;

endmodule
